// File: rtl/fir_decimator.sv
// Three-tap signed FIR with arithmetic shift, 8-bit saturation and 1/2/4/8 decimation.
// Three register stages from an accepted sample to the registered output strobe.
module fir_decimator #(
    parameter int DW    = 8,
    parameter int NTAPS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [DW-1:0] I_adc_data,
    input  logic                 I_adc_valid,
    input  logic                 I_conv_en,
    input  logic signed [DW-1:0] I_coef0,
    input  logic signed [DW-1:0] I_coef1,
    input  logic signed [DW-1:0] I_coef2,
    input  logic signed [DW-1:0] I_coef_div,
    input  logic        [1:0]    I_decimation_ratio,
    output logic signed [DW-1:0] O_filt_data,
    output logic                 O_filt_valid,
    output logic                 O_filt_sat
);

    localparam int PW = 2 * DW;
    localparam int SW = PW + $clog2(NTAPS);
    localparam logic signed [SW-1:0] MAX_V = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);

    logic signed [DW-1:0] x1_q, x2_q;
    logic        [2:0]    cnt_q;
    logic signed [PW-1:0] p0_q, p1_q, p2_q;
    logic        [4:0]    sh1_q, sh2_q;
    logic                 v1_q, v2_q;
    logic signed [SW-1:0] s_q;

    logic                 accept;
    logic        [2:0]    mask_d;
    logic                 emit_d;
    logic        [4:0]    sh_d;
    logic signed [PW-1:0] p0_d, p1_d, p2_d;
    logic signed [SW-1:0] s_d, r_d;
    logic signed [DW-1:0] sat_data_d;
    logic                 clip_d;

    assign accept = I_adc_valid & I_conv_en;
    assign mask_d = (3'b001 << I_decimation_ratio) - 3'd1;
    assign emit_d = ((cnt_q & mask_d) == 3'd0);

    assign p0_d = PW'(I_coef0) * PW'(I_adc_data);
    assign p1_d = PW'(I_coef1) * PW'(x1_q);
    assign p2_d = PW'(I_coef2) * PW'(x2_q);
    assign s_d  = SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
    assign r_d  = s_q >>> sh2_q;

    // Negative shift means no shift; anything past 17 already reduces the sum to 0 or -1.
    always_comb begin
        sh_d = 5'd0;
        if (I_coef_div[DW-1]) begin
            sh_d = 5'd0;
        end else if (I_coef_div > DW'(17)) begin
            sh_d = 5'd17;
        end else begin
            sh_d = I_coef_div[4:0];
        end
    end

    always_comb begin
        sat_data_d = r_d[DW-1:0];
        clip_d     = 1'b0;
        if (r_d > MAX_V) begin
            sat_data_d = MAX_V[DW-1:0];
            clip_d     = 1'b1;
        end else if (r_d < MIN_V) begin
            sat_data_d = MIN_V[DW-1:0];
            clip_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x1_q         <= '0;
            x2_q         <= '0;
            cnt_q        <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            sh1_q        <= '0;
            sh2_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            s_q          <= '0;
            O_filt_data  <= '0;
            O_filt_valid <= 1'b0;
            O_filt_sat   <= 1'b0;
        end else if (!I_conv_en) begin
            // Abort: drop history and in-flight samples, keep the last presented value.
            x1_q         <= '0;
            x2_q         <= '0;
            cnt_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            O_filt_valid <= 1'b0;
            O_filt_sat   <= 1'b0;
        end else begin
            if (accept) begin
                x1_q  <= I_adc_data;
                x2_q  <= x1_q;
                cnt_q <= cnt_q + 3'd1;
                p0_q  <= p0_d;
                p1_q  <= p1_d;
                p2_q  <= p2_d;
                sh1_q <= sh_d;
                v1_q  <= emit_d;
            end else begin
                v1_q  <= 1'b0;
            end
            s_q          <= s_d;
            sh2_q        <= sh1_q;
            v2_q         <= v1_q;
            O_filt_valid <= v2_q;
            if (v2_q) begin
                O_filt_data <= sat_data_d;
                O_filt_sat  <= clip_d;
            end else begin
                O_filt_sat  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: a reference model queues expected samples
// with their due cycle as stimulus is driven; a negedge monitor pops and compares.
module tb_fir_decimator;

    logic              clk = 1'b0;
    logic              reset_n;
    logic signed [7:0] I_adc_data;
    logic              I_adc_valid;
    logic              I_conv_en;
    logic signed [7:0] I_coef0, I_coef1, I_coef2, I_coef_div;
    logic        [1:0] I_decimation_ratio;
    logic signed [7:0] O_filt_data;
    logic              O_filt_valid;
    logic              O_filt_sat;

    fir_decimator dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .I_adc_data         (I_adc_data),
        .I_adc_valid        (I_adc_valid),
        .I_conv_en          (I_conv_en),
        .I_coef0            (I_coef0),
        .I_coef1            (I_coef1),
        .I_coef2            (I_coef2),
        .I_coef_div         (I_coef_div),
        .I_decimation_ratio (I_decimation_ratio),
        .O_filt_data        (O_filt_data),
        .O_filt_valid       (O_filt_valid),
        .O_filt_sat         (O_filt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  data;
        int  sat;
        int  due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rst_seen = 1'b0;
    int   last_data = 0;
    int   n_valid  = 0;
    int   m_x1 = 0, m_x2 = 0, m_cnt = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model accordingly.
    task automatic drive(input bit rstn, input bit en, input bit vld, input int x);
        int s, sh, r, sat, mask, div;
        exp_t e;
        reset_n     = rstn;
        I_conv_en   = en;
        I_adc_valid = vld;
        I_adc_data  = x[7:0];
        if (!rstn || !en) begin
            m_x1 = 0; m_x2 = 0; m_cnt = 0;
            while (q.size() > 0 && q[$].due > cyc) q.pop_back();
        end else if (vld) begin
            s   = int'(I_coef0) * x + int'(I_coef1) * m_x1 + int'(I_coef2) * m_x2;
            div = int'(I_coef_div);
            sh  = (div < 0) ? 0 : ((div > 17) ? 17 : div);
            r   = s >>> sh;
            sat = 0;
            if (r > 127) begin r = 127; sat = 1; end
            else if (r < -128) begin r = -128; sat = 1; end
            mask = (1 << I_decimation_ratio) - 1;
            if ((m_cnt & mask) == 0) begin
                e.data = r; e.sat = sat; e.due = cyc + 3;
                q.push_back(e);
            end
            m_x2  = m_x1;
            m_x1  = x;
            m_cnt = (m_cnt + 1) % 8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int div);
        I_coef0 = 8'(c0); I_coef1 = 8'(c1); I_coef2 = 8'(c2); I_coef_div = 8'(div);
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !reset_n;
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_seen) begin
                check_val("rst_data", int'(O_filt_data), 0);
                check_val("rst_valid", int'(O_filt_valid), 0);
                check_val("rst_sat", int'(O_filt_sat), 0);
                last_data = 0;
            end else if (O_filt_valid) begin
                n_valid++;
                if (q.size() == 0) begin
                    check_val("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_val("latency", cyc, e.due);
                    check_val("data", int'(O_filt_data), e.data);
                    check_val("sat", int'(O_filt_sat), e.sat);
                    last_data = e.data;
                end
            end else begin
                check_val("hold_data", int'(O_filt_data), last_data);
                check_val("sat_idle", int'(O_filt_sat), 0);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    check_val("missing_valid", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int n0;
        reset_n = 1'b0; I_conv_en = 1'b0; I_adc_valid = 1'b0; I_adc_data = '0;
        I_decimation_ratio = 2'd0;
        set_coefs(0, 0, 0, 0);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            set_coefs($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255));
            I_decimation_ratio = 2'($urandom_range(0, 3));
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)) - 128);
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0);

        // Impulse
        set_coefs(1, 2, 3, 0);
        I_decimation_ratio = 2'd0;
        drive(1'b1, 1'b1, 1'b1, 10);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 0);
        idle(5);

        // Saturation
        set_coefs(127, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 127);
        drive(1'b1, 1'b1, 1'b1, -128);
        set_coefs(1, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, -5);
        idle(5);

        // Shift: positive, negative and oversize amounts
        set_coefs(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, -3);
        I_coef_div = -8'sd4;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, -3);
        I_coef_div = 8'sd20;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, -3);
        idle(5);

        // Decimation by 4 with gaps, after a disable to restart the phase
        drive(1'b1, 1'b0, 1'b0, 0);
        set_coefs(1, 0, 0, 0);
        I_decimation_ratio = 2'd2;
        n0 = n_valid;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 1'b1, 1'b1, 10 * i);
            drive(1'b1, 1'b1, 1'b0, 0);
        end
        idle(5);
        check_val("dec_count", n_valid - n0, 3);
        I_decimation_ratio = 2'd0;
        n0 = n_valid;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 7 + i);
        idle(5);
        check_val("ratio0_count", n_valid - n0, 4);

        // Abort with two samples in flight, then re-enable
        set_coefs(2, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 30);
        drive(1'b1, 1'b1, 1'b1, 31);
        n0 = n_valid;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, i[0], 50);
        check_val("abort_count", n_valid - n0, 0);
        set_coefs(1, 1, 1, 0);
        drive(1'b1, 1'b1, 1'b1, 4);
        idle(5);

        // Mid-stream reset clears the presented value
        drive(1'b1, 1'b1, 1'b1, 9);
        drive(1'b0, 1'b1, 1'b1, 9);
        drive(1'b1, 1'b1, 1'b0, 0);
        idle(5);

        check_val("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
